// File: rtl/axi_burst_sequencer.sv
// axi_burst_sequencer: turns one-at-a-time L2 memory requests into AXI4 AR/AW/W/B phases on a 32-bit master port.
// Latency: request to arvalid/awvalid is 1 cycle; the R channel is a zero-latency passthrough to rd_*.
// Backpressure: req_ready pulses on the AR/AW handshake; reads stall at MAX_READS outstanding, writes wait for all reads to drain.
// Ports: clk/rst; req_* request in (valid/ready); wr_* write beats in; rd_* read beats out;
//        axi_ar*/axi_aw*/axi_w* master outputs with their ready inputs; axi_b*/axi_r* response inputs.
module axi_burst_sequencer #(
  parameter int MAX_READS = 4,
  parameter int ID_W      = 6
) (
  input  logic            clk,
  input  logic            rst,
  // request port from the L2 arbiter
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [29:0]     req_addr,
  input  logic            req_rnw,
  input  logic [4:0]      req_len,
  input  logic [ID_W-1:0] req_id,
  // write beats
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [31:0]     wr_data,
  input  logic [3:0]      wr_be,
  // read beats
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [31:0]     rd_data,
  output logic [ID_W-1:0] rd_id,
  output logic            rd_last,
  // AXI read address
  output logic [31:0]     axi_araddr,
  output logic [7:0]      axi_arlen,
  output logic [2:0]      axi_arsize,
  output logic [1:0]      axi_arburst,
  output logic [3:0]      axi_arcache,
  output logic [ID_W-1:0] axi_arid,
  output logic            axi_arvalid,
  input  logic            axi_arready,
  // AXI write address
  output logic [31:0]     axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic [3:0]      axi_awcache,
  output logic [ID_W-1:0] axi_awid,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  // AXI write data
  output logic [31:0]     axi_wdata,
  output logic [3:0]      axi_wstrb,
  output logic            axi_wlast,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  // AXI write response
  input  logic            axi_bvalid,
  input  logic [1:0]      axi_bresp,
  input  logic [ID_W-1:0] axi_bid,
  output logic            axi_bready,
  // AXI read data
  input  logic            axi_rvalid,
  input  logic [31:0]     axi_rdata,
  input  logic [ID_W-1:0] axi_rid,
  input  logic            axi_rlast,
  input  logic [1:0]      axi_rresp,
  output logic            axi_rready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t          state;
  logic [29:0]     ar_addr;
  logic [4:0]      ar_len;
  logic [ID_W-1:0] ar_id;
  logic [29:0]     aw_addr;
  logic [4:0]      aw_len;
  logic [ID_W-1:0] aw_id;
  logic            arvalid_q;
  logic            awvalid_q;
  logic            bready_q;
  logic [3:0]      read_count;
  logic [4:0]      beat_count;

  logic in_wdata;
  logic ar_hs;
  logic r_last_hs;
  logic w_hs;
  logic last_beat;

  // Write response code and id are not needed: one write is in flight at a time.
  logic unused_resp;
  assign unused_resp = ^{axi_bresp, axi_bid, axi_rresp};

  assign in_wdata  = (state == WR_DATA);
  assign ar_hs     = arvalid_q & axi_arready;
  assign r_last_hs = axi_rvalid & rd_ready & axi_rlast;
  assign w_hs      = in_wdata & wr_valid & axi_wready;
  assign last_beat = (beat_count == aw_len);

  // The request is consumed exactly when its address phase is accepted.
  assign req_ready = ((state == RD_ADDR) & axi_arready) | ((state == WR_ADDR) & axi_awready);

  assign axi_araddr  = {ar_addr, 2'b00};
  assign axi_arlen   = {3'b000, ar_len};
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arcache = 4'b0011;
  assign axi_arid    = ar_id;
  assign axi_arvalid = arvalid_q;

  assign axi_awaddr  = {aw_addr, 2'b00};
  assign axi_awlen   = {3'b000, aw_len};
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awcache = 4'b0011;
  assign axi_awid    = aw_id;
  assign axi_awvalid = awvalid_q;

  // W beats pass straight through, gated so nothing leaks outside the data phase.
  assign axi_wdata  = wr_data;
  assign axi_wstrb  = wr_be;
  assign axi_wvalid = wr_valid & in_wdata;
  assign axi_wlast  = in_wdata & last_beat;
  assign wr_ready   = axi_wready & in_wdata;

  assign axi_bready = bready_q;

  assign rd_valid   = axi_rvalid;
  assign rd_data    = axi_rdata;
  assign rd_id      = axi_rid;
  assign rd_last    = axi_rlast;
  assign axi_rready = rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ar_addr    <= '0;
      ar_len     <= '0;
      ar_id      <= '0;
      aw_addr    <= '0;
      aw_len     <= '0;
      aw_id      <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      read_count <= '0;
      beat_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Head-of-line blocking: a stalled request is never bypassed.
          if (req_valid && req_rnw && (read_count < 4'(MAX_READS))) begin
            ar_addr   <= req_addr;
            ar_len    <= req_len;
            ar_id     <= req_id;
            arvalid_q <= 1'b1;
            state     <= RD_ADDR;
          end else if (req_valid && !req_rnw && (read_count == 4'd0)) begin
            aw_addr    <= req_addr;
            aw_len     <= req_len;
            aw_id      <= req_id;
            beat_count <= '0;
            awvalid_q  <= 1'b1;
            state      <= WR_ADDR;
          end
        end
        RD_ADDR: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        WR_ADDR: begin
          if (axi_awready) begin
            awvalid_q <= 1'b0;
            state     <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            beat_count <= beat_count + 5'd1;
            if (last_beat) begin
              bready_q <= 1'b1;
              state    <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (axi_bvalid) begin
            bready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Issue and retire may coincide; the count only moves on one of them alone.
      if (ar_hs && !r_last_hs) begin
        read_count <= read_count + 4'd1;
      end else if (!ar_hs && r_last_hs && (read_count != 4'd0)) begin
        read_count <= read_count - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_sequencer.sv
module tb_axi_burst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rnw;
  logic [29:0] req_addr;
  logic [4:0]  req_len;
  logic [5:0]  req_id;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic [5:0]  rd_id;
  logic [31:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [1:0]  axi_arburst, axi_awburst, axi_bresp, axi_rresp;
  logic [3:0]  axi_arcache, axi_awcache, axi_wstrb;
  logic [5:0]  axi_arid, axi_awid, axi_bid, axi_rid;
  logic        axi_arvalid, axi_arready, axi_awvalid, axi_awready;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_rvalid, axi_rlast, axi_rready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_burst_sequencer #(.MAX_READS(4), .ID_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rnw(req_rnw),
    .req_len(req_len), .req_id(req_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arcache(axi_arcache), .axi_arid(axi_arid), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awcache(axi_awcache), .axi_awid(axi_awid), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bid(axi_bid), .axi_bready(axi_bready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast),
    .axi_rresp(axi_rresp), .axi_rready(axi_rready)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request with the slave always ready; ok reports whether it was consumed.
  task automatic issue_req(input logic rnw, input logic [29:0] a, input logic [4:0] l,
                           input logic [5:0] id, output bit ok);
    bit got;
    req_valid = 1'b1; req_rnw = rnw; req_addr = a; req_len = l; req_id = id;
    axi_arready = 1'b1; axi_awready = 1'b1; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      got = req_ready;
      step();
      if (got) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0; axi_arready = 1'b0; axi_awready = 1'b0;
  endtask

  // One read beat accepted immediately by the consumer.
  task automatic r_beat(input logic [31:0] d, input logic [5:0] id, input logic last);
    axi_rvalid = 1'b1; axi_rdata = d; axi_rid = id; axi_rlast = last; axi_rresp = 2'b00; rd_ready = 1'b1;
    step();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, req_ready, wr_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valids got ar=%b aw=%b w=%b b=%b req_rdy=%b wr_rdy=%b exp all 0",
               axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, req_ready, wr_ready);
    end
    checks++;
    if (dut.read_count !== 4'd0) begin
      failures++; $display("FAIL reset_read_count got %0d exp 0", dut.read_count);
    end
    checks++;
    if (axi_araddr !== 32'd0 || axi_arlen !== 8'd0 || axi_arid !== 6'd0 ||
        axi_awaddr !== 32'd0 || axi_awlen !== 8'd0 || axi_awid !== 6'd0) begin
      failures++;
      $display("FAIL reset_addr_regs got araddr=%h arlen=%0d arid=%0d awaddr=%h awlen=%0d awid=%0d exp all 0",
               axi_araddr, axi_arlen, axi_arid, axi_awaddr, axi_awlen, axi_awid);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    logic [31:0] rdat[4];
    int rdy_cycles = 0;
    int beat = 0;
    for (int i = 0; i < 4; i++) rdat[i] = $urandom;
    req_valid = 1'b1; req_rnw = 1'b1; req_addr = 30'h100; req_len = 5'd3; req_id = 6'd5;
    axi_arready = 1'b0;
    step();
    checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h400 || axi_arlen !== 8'd3 || axi_arid !== 6'd5) begin
      failures++;
      $display("FAIL read_ar_payload got v=%b addr=%h len=%0d id=%0d exp v=1 addr=400 len=3 id=5",
               axi_arvalid, axi_araddr, axi_arlen, axi_arid);
    end
    checks++;
    if (axi_arsize !== 3'b010 || axi_arburst !== 2'b01 || axi_arcache !== 4'b0011) begin
      failures++;
      $display("FAIL read_ar_const got size=%b burst=%b cache=%b exp 010 01 0011",
               axi_arsize, axi_arburst, axi_arcache);
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      if (req_ready) rdy_cycles++;
      checks++;
      if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h400) begin
        failures++; $display("FAIL read_ar_hold got v=%b addr=%h exp v=1 addr=400", axi_arvalid, axi_araddr);
      end
      step();
    end
    axi_arready = 1'b1;
    #1;
    if (req_ready) rdy_cycles++;
    step();
    req_valid = 1'b0; axi_arready = 1'b0;
    #1;
    if (req_ready) rdy_cycles++;
    checks++;
    if (rdy_cycles !== 1 || axi_arvalid !== 1'b0) begin
      failures++; $display("FAIL read_req_ready got cycles=%0d arvalid=%b exp cycles=1 arvalid=0", rdy_cycles, axi_arvalid);
    end
    for (int c = 0; c < 40 && beat < 4; c++) begin
      axi_rvalid = 1'b1; axi_rdata = rdat[beat]; axi_rid = 6'd5; axi_rlast = (beat == 3);
      axi_rresp = 2'b00; rd_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== rdat[beat] || rd_id !== 6'd5 || rd_last !== (beat == 3) ||
          axi_rready !== rd_ready) begin
        failures++;
        $display("FAIL read_passthru beat=%0d got v=%b d=%h id=%0d last=%b rready=%b exp v=1 d=%h id=5 last=%b rready=%b",
                 beat, rd_valid, rd_data, rd_id, rd_last, axi_rready, rdat[beat], (beat == 3), rd_ready);
      end
      checks++;
      if (dut.read_count !== 4'd1) begin
        failures++; $display("FAIL read_count_busy got %0d exp 1", dut.read_count);
      end
      step();
      if (rd_ready) beat++;
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0; rd_ready = 1'b0;
    checks++;
    if (beat !== 4 || dut.read_count !== 4'd0) begin
      failures++; $display("FAIL read_done got beats=%0d count=%0d exp beats=4 count=0", beat, dut.read_count);
    end
  endtask

  task automatic test_outstanding();
    logic [29:0] a[5];
    logic [5:0]  id[5];
    int hs = 0;
    int accepted = 0;
    int model_out = 0;
    bit got;
    bit seen;
    for (int r = 0; r < 5; r++) begin
      a[r] = 30'($urandom); id[r] = 6'($urandom);
    end
    axi_arready = 1'b1; req_rnw = 1'b1; req_len = 5'd0;
    for (int r = 0; r < 5; r++) begin
      req_valid = 1'b1; req_addr = a[r]; req_id = id[r]; got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (axi_arvalid) begin
          hs++;
          checks++;
          if (axi_araddr !== {a[r], 2'b00} || axi_arid !== id[r] || axi_arlen !== 8'd0) begin
            failures++;
            $display("FAIL outst_ar_payload r=%0d got addr=%h id=%0d exp addr=%h id=%0d",
                     r, axi_araddr, axi_arid, {a[r], 2'b00}, id[r]);
          end
        end
        got = req_ready;
        step();
        if (got) break;
      end
      if (got) begin
        accepted++; model_out++;
      end else begin
        break;
      end
    end
    checks++;
    if (hs !== 4 || accepted !== 4) begin
      failures++; $display("FAIL outst_limit got handshakes=%0d accepted=%0d exp 4 4", hs, accepted);
    end
    checks++;
    if (dut.read_count !== 4'(model_out)) begin
      failures++; $display("FAIL outst_count got %0d exp %0d", dut.read_count, model_out);
    end
    // first read retires; the held fifth request must not issue in that same cycle
    axi_rvalid = 1'b1; axi_rdata = $urandom; axi_rid = id[0]; axi_rlast = 1'b1; rd_ready = 1'b1;
    #1;
    checks++;
    if (axi_arvalid !== 1'b0) begin
      failures++; $display("FAIL outst_early_ar got arvalid=%b exp 0", axi_arvalid);
    end
    step();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; rd_ready = 1'b0;
    model_out--;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (axi_arvalid) begin
        seen = 1'b1;
        checks++;
        if (axi_araddr !== {a[4], 2'b00} || axi_arid !== id[4]) begin
          failures++;
          $display("FAIL outst_fifth_payload got addr=%h id=%0d exp addr=%h id=%0d",
                   axi_araddr, axi_arid, {a[4], 2'b00}, id[4]);
        end
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0; axi_arready = 1'b0;
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL outst_fifth_issue got seen=%b exp 1", seen);
    end
    if (seen) model_out++;
    for (int k = 1; k < 5; k++) r_beat($urandom, id[k], 1'b1);
    model_out = model_out - 4;
    checks++;
    if (dut.read_count !== 4'(model_out)) begin
      failures++; $display("FAIL outst_drain got %0d exp %0d", dut.read_count, model_out);
    end
  endtask

  task automatic test_write();
    logic [31:0] wd[8];
    logic [3:0]  wb[8];
    int idx = 0;
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom; wb[i] = 4'($urandom);
    end
    req_valid = 1'b1; req_rnw = 1'b0; req_addr = 30'h20; req_len = 5'd7; req_id = 6'd9;
    axi_awready = 1'b0;
    step();
    checks++;
    if (axi_awvalid !== 1'b1 || axi_awaddr !== 32'h80 || axi_awlen !== 8'd7 || axi_awid !== 6'd9 ||
        axi_awsize !== 3'b010 || axi_awburst !== 2'b01 || axi_awcache !== 4'b0011) begin
      failures++;
      $display("FAIL write_aw_payload got v=%b addr=%h len=%0d id=%0d size=%b burst=%b cache=%b exp 1 80 7 9 010 01 0011",
               axi_awvalid, axi_awaddr, axi_awlen, axi_awid, axi_awsize, axi_awburst, axi_awcache);
    end
    wr_valid = 1'b1; axi_wready = 1'b1;
    #1;
    checks++;
    if (axi_wvalid !== 1'b0 || wr_ready !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_w_gated got wvalid=%b wr_ready=%b req_ready=%b exp 0 0 0", axi_wvalid, wr_ready, req_ready);
    end
    wr_valid = 1'b0; axi_wready = 1'b0; axi_awready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL write_req_ready got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0; axi_awready = 1'b0;
    for (int c = 0; c < 200 && idx < 8; c++) begin
      wr_valid = (c % 2 == 0); wr_data = wd[idx]; wr_be = wb[idx]; axi_wready = 1'($urandom);
      #1;
      checks++;
      if (axi_wvalid !== wr_valid || wr_ready !== axi_wready) begin
        failures++;
        $display("FAIL write_w_hs got wvalid=%b wr_ready=%b exp %b %b", axi_wvalid, wr_ready, wr_valid, axi_wready);
      end
      if (wr_valid) begin
        checks++;
        if (axi_wdata !== wd[idx] || axi_wstrb !== wb[idx] || axi_wlast !== (idx == 7)) begin
          failures++;
          $display("FAIL write_beat idx=%0d got d=%h strb=%h last=%b exp d=%h strb=%h last=%b",
                   idx, axi_wdata, axi_wstrb, axi_wlast, wd[idx], wb[idx], (idx == 7));
        end
      end
      if (wr_valid && axi_wready) idx++;
      step();
    end
    wr_valid = 1'b0; axi_wready = 1'b0;
    checks++;
    if (idx !== 8) begin
      failures++; $display("FAIL write_beat_count got %0d exp 8", idx);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (axi_bready !== 1'b1 || axi_wvalid !== 1'b0) begin
        failures++; $display("FAIL write_bready_wait got bready=%b wvalid=%b exp 1 0", axi_bready, axi_wvalid);
      end
      step();
    end
    axi_bvalid = 1'b1; axi_bresp = 2'($urandom); axi_bid = 6'd9;
    step();
    axi_bvalid = 1'b0;
    wr_valid = 1'b1; axi_wready = 1'b1;
    #1;
    checks++;
    if (axi_bready !== 1'b0 || axi_wvalid !== 1'b0 || axi_awvalid !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_done got bready=%b wvalid=%b awvalid=%b wr_ready=%b exp 0 0 0 0",
               axi_bready, axi_wvalid, axi_awvalid, wr_ready);
    end
    wr_valid = 1'b0; axi_wready = 1'b0;
  endtask

  task automatic test_ordering();
    bit ok;
    bit seen;
    logic [5:0] id0, id1;
    id0 = 6'($urandom); id1 = 6'($urandom);
    issue_req(1'b1, 30'($urandom), 5'd0, id0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL order_read0 got consumed=0 exp 1"); end
    issue_req(1'b1, 30'($urandom), 5'd0, id1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL order_read1 got consumed=0 exp 1"); end
    req_valid = 1'b1; req_rnw = 1'b0; req_addr = 30'($urandom); req_len = 5'd0; req_id = 6'd3;
    axi_awready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (axi_awvalid !== 1'b0) begin failures++; $display("FAIL order_aw_blocked got awvalid=1 exp 0"); end
      step();
    end
    axi_rvalid = 1'b1; axi_rid = id0; axi_rlast = 1'b1; rd_ready = 1'b1;
    step();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; rd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (axi_awvalid !== 1'b0) begin failures++; $display("FAIL order_aw_one_left got awvalid=1 exp 0"); end
      step();
    end
    axi_rvalid = 1'b1; axi_rid = id1; axi_rlast = 1'b1; rd_ready = 1'b1;
    #1;
    checks++;
    if (axi_awvalid !== 1'b0) begin failures++; $display("FAIL order_aw_last_cycle got awvalid=1 exp 0"); end
    step();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; rd_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (axi_awvalid) begin
        seen = 1'b1;
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0; axi_awready = 1'b0;
    checks++;
    if (!seen) begin failures++; $display("FAIL order_aw_issue got awvalid never exp 1"); end
    wr_valid = 1'b1; wr_data = $urandom; wr_be = 4'hF; axi_wready = 1'b1;
    #1;
    checks++;
    if (axi_wvalid !== 1'b1 || axi_wlast !== 1'b1) begin
      failures++; $display("FAIL order_single_beat got wvalid=%b wlast=%b exp 1 1", axi_wvalid, axi_wlast);
    end
    step();
    wr_valid = 1'b0; axi_wready = 1'b0;
    req_valid = 1'b1; req_rnw = 1'b1; req_addr = 30'($urandom); req_len = 5'd0; req_id = id0;
    axi_arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (axi_arvalid !== 1'b0 || axi_bready !== 1'b1) begin
        failures++; $display("FAIL order_ar_blocked got arvalid=%b bready=%b exp 0 1", axi_arvalid, axi_bready);
      end
      step();
    end
    axi_bvalid = 1'b1;
    #1;
    checks++;
    if (axi_arvalid !== 1'b0) begin failures++; $display("FAIL order_ar_bcycle got arvalid=1 exp 0"); end
    step();
    axi_bvalid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (axi_arvalid) begin
        seen = 1'b1;
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0; axi_arready = 1'b0;
    checks++;
    if (!seen) begin failures++; $display("FAIL order_ar_issue got arvalid never exp 1"); end
    r_beat($urandom, id0, 1'b1);
    checks++;
    if (dut.read_count !== 4'd0) begin
      failures++; $display("FAIL order_drain got %0d exp 0", dut.read_count);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int model_out = 0;
    for (int r = 0; r < 2; r++) begin
      issue_req(1'b1, 30'($urandom), 5'd0, 6'(r), ok);
      if (ok) model_out++;
    end
    req_valid = 1'b1; req_rnw = 1'b1; req_addr = 30'($urandom); req_len = 5'd0; req_id = 6'd2;
    axi_arready = 1'b0;
    step();
    checks++;
    if (axi_arvalid !== 1'b1 || dut.read_count !== 4'(model_out)) begin
      failures++;
      $display("FAIL simul_setup got arvalid=%b count=%0d exp 1 %0d", axi_arvalid, dut.read_count, model_out);
    end
    axi_arready = 1'b1;
    axi_rvalid = 1'b1; axi_rid = 6'd0; axi_rlast = 1'b1; rd_ready = 1'b1;
    step();
    req_valid = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b0; axi_rlast = 1'b0; rd_ready = 1'b0;
    checks++;
    if (dut.read_count !== 4'(model_out)) begin
      failures++; $display("FAIL simul_count got %0d exp %0d", dut.read_count, model_out);
    end
    r_beat($urandom, 6'd1, 1'b1);
    r_beat($urandom, 6'd2, 1'b1);
    checks++;
    if (dut.read_count !== 4'd0) begin
      failures++; $display("FAIL simul_drain got %0d exp 0", dut.read_count);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    logic [29:0] a;
    logic [4:0]  l;
    logic [5:0]  id;
    issue_req(1'b0, 30'($urandom), 5'd7, 6'd4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstw_aw got consumed=0 exp 1"); end
    wr_valid = 1'b1; axi_wready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      wr_data = $urandom; wr_be = 4'hF;
      step();
    end
    rst = 1'b1;
    step();
    #1;
    checks++;
    if ({axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, wr_ready, req_ready} !== 6'b0) begin
      failures++;
      $display("FAIL rstw_valids got ar=%b aw=%b w=%b b=%b wr_rdy=%b req_rdy=%b exp all 0",
               axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, wr_ready, req_ready);
    end
    rst = 1'b0; wr_valid = 1'b0; axi_wready = 1'b0;
    step();
    a = 30'($urandom); l = 5'($urandom_range(0, 3)); id = 6'($urandom);
    req_valid = 1'b1; req_rnw = 1'b1; req_addr = a; req_len = l; req_id = id;
    axi_arready = 1'b0;
    step();
    checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== {a, 2'b00} || axi_arlen !== {3'b000, l} || axi_arid !== id) begin
      failures++;
      $display("FAIL rstw_fresh_read got v=%b addr=%h len=%0d id=%0d exp 1 %h %0d %0d",
               axi_arvalid, axi_araddr, axi_arlen, axi_arid, {a, 2'b00}, l, id);
    end
    axi_arready = 1'b1;
    step();
    req_valid = 1'b0; axi_arready = 1'b0;
    for (int k = 0; k <= int'(l); k++) r_beat($urandom, id, (k == int'(l)));
    checks++;
    if (dut.read_count !== 4'd0 || axi_arvalid !== 1'b0) begin
      failures++; $display("FAIL rstw_done got count=%0d arvalid=%b exp 0 0", dut.read_count, axi_arvalid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_len = '0; req_id = '0;
    wr_valid = 1'b0; wr_data = '0; wr_be = '0; rd_ready = 1'b0;
    axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
    axi_bvalid = 1'b0; axi_bresp = '0; axi_bid = '0;
    axi_rvalid = 1'b0; axi_rdata = '0; axi_rid = '0; axi_rlast = 1'b0; axi_rresp = '0;
    test_reset();
    test_single_read();
    test_outstanding();
    test_write();
    test_ordering();
    test_simultaneous();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
